// File: rtl/bcd_down_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_timer_pkg
// Brief    : Shared types and constants for the BCD countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_down_timer_pkg;

  // Largest legal value of one BCD decade
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Timer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Out-of-range decades are saturated to 9 so the count is always valid BCD
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_timer_if
// Brief    : Control/status bundle between a timer user and the timer.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_down_timer_if #(
  parameter int DIGITS = 2
) ();

  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   count_out;
  logic                  busy;
  logic                  done;
  logic                  expired;

  modport master (
    output load, load_val, start, pause,
    input  count_out, busy, done, expired
  );

  modport slave (
    input  load, load_val, start, pause,
    output count_out, busy, done, expired
  );

endinterface
`default_nettype wire

// File: rtl/bcd_down_timer_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_digit
// Brief    : One BCD decade with clamped parallel load and borrow chain.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_digit
  import bcd_down_timer_pkg::*;
(
  input  wire logic       CLK,
  input  wire logic       reset,
  input  wire logic       load_i,
  input  wire logic [3:0] d_i,
  input  wire logic       borrow_i,
  output logic      [3:0] q_o,
  output logic            borrow_o,
  output logic            is_zero_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next decade value: load wins, otherwise step down on an incoming borrow
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = clamp_digit(d_i);
    end else if (borrow_i) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
    end
  end

  // Decade register, cleared asynchronously
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) q_q <= 4'd0;
    else        q_q <= q_d;
  end

  assign q_o       = q_q;
  assign is_zero_o = (q_q == 4'd0);
  assign borrow_o  = borrow_i & (q_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_timer
// Brief    : Multi-decade BCD countdown timer with load/start/pause control.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_timer
  import bcd_down_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  wire logic         CLK,
  input  wire logic         reset,
  bcd_down_timer_if.slave   bus
);

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                w_dec;
  logic                w_upper_zero;
  logic                w_one;
  logic                w_count_zero;
  logic [DIGITS:0]     w_borrow;
  logic [DIGITS-1:0]   w_is_zero;
  logic [4*DIGITS-1:0] w_count;

  // The lowest decade always takes the step's borrow; higher decades chain
  assign w_borrow[0] = w_dec;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_down_digit u_digit (
        .CLK       (CLK),
        .reset     (reset),
        .load_i    (bus.load),
        .d_i       (bus.load_val[4*gi +: 4]),
        .borrow_i  (w_borrow[gi]),
        .q_o       (w_count[4*gi +: 4]),
        .borrow_o  (w_borrow[gi+1]),
        .is_zero_o (w_is_zero[gi])
      );
    end
  endgenerate

  // Count==1 means the next step lands on zero, so done can be registered
  // and line up with the first cycle count_out shows zero
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      w_upper_zero = w_upper_zero & w_is_zero[i];
    end
    w_count_zero = &w_is_zero;
    w_one        = (w_count[3:0] == 4'd1) & w_upper_zero;
  end

  // Next-state, decrement enable and done pulse; load overrides everything
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    w_dec   = 1'b0;
    if (bus.load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (w_count_zero) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_HOLD;
          end else begin
            w_dec = 1'b1;
            if (w_one) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.start && !bus.pause) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and done-pulse registers, cleared asynchronously
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign bus.count_out = w_count;
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign bus.expired   = (state_q == ST_DONE);
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_down_timer
// Brief    : Self-checking bench for bcd_down_timer against a numeric model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_down_timer;

  logic CLK = 1'b0;
  logic reset;

  always #5 CLK = ~CLK;

  bcd_down_timer_if #(.DIGITS(2)) bus ();

  bcd_down_timer #(.DIGITS(2)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain integer count plus activity flags
  int m_val;
  bit m_run, m_hold, m_fin, m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_val(input logic [7:0] v);
    int hi, lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'((n / 10) % 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic model_clear();
    m_val = 0; m_run = 0; m_hold = 0; m_fin = 0; m_done = 0;
  endtask

  task automatic model_step(input bit ld, input logic [7:0] v, input bit st, input bit pa);
    m_done = 0;
    if (ld) begin
      m_val = clamp_val(v); m_run = 0; m_hold = 0; m_fin = 0;
    end else if (m_fin) begin
      // finished: wait for load
    end else if (m_run) begin
      if (pa) begin
        m_run = 0; m_hold = 1;
      end else begin
        m_val = m_val - 1;
        if (m_val == 0) begin m_run = 0; m_fin = 1; m_done = 1; end
      end
    end else if (m_hold) begin
      if (st && !pa) begin m_hold = 0; m_run = 1; end
    end else if (st) begin
      if (m_val == 0) begin m_fin = 1; m_done = 1; end
      else m_run = 1;
    end
  endtask

  task automatic cmp_all(input string tag);
    check({tag, ".count"},   32'(bus.count_out), 32'(to_bcd(m_val)));
    check({tag, ".busy"},    32'(bus.busy),      32'(m_run | m_hold));
    check({tag, ".done"},    32'(bus.done),      32'(m_done));
    check({tag, ".expired"}, 32'(bus.expired),   32'(m_fin));
  endtask

  task automatic step(input bit ld, input logic [7:0] v, input bit st, input bit pa, input string tag);
    bus.load = ld; bus.load_val = v; bus.start = st; bus.pause = pa;
    @(posedge CLK);
    model_step(ld, v, st, pa);
    #1;
    cmp_all(tag);
  endtask

  // Asynchronous reset applied between clock edges and checked immediately
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    cmp_all(tag);
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus.load = 0; bus.load_val = 0; bus.start = 0; bus.pause = 0;
    model_clear();
    repeat (2) @(negedge CLK);
    cmp_all("reset");
    reset = 1'b1;

    // countdown from 25 to zero with one done pulse
    step(1, 8'h25, 0, 0, "t2_load");
    step(0, 8'h00, 1, 0, "t2_start");
    for (int k = 0; k < 25; k++) step(0, 8'h00, 0, 0, "t2_run");
    check("t2_zero", 32'(bus.count_out), 32'h00);
    check("t2_done", 32'(bus.done), 32'd1);
    step(0, 8'h00, 1, 0, "t2_after");
    check("t2_expired", 32'(bus.expired), 32'd1);

    // borrow across decades
    step(1, 8'h10, 0, 0, "t3_load");
    step(0, 8'h00, 1, 0, "t3_start");
    step(0, 8'h00, 0, 0, "t3_s1");
    check("t3_09", 32'(bus.count_out), 32'h09);
    step(0, 8'h00, 0, 0, "t3_s2");
    check("t3_08", 32'(bus.count_out), 32'h08);

    // pause and resume
    step(1, 8'h50, 0, 0, "t4_load");
    step(0, 8'h00, 1, 0, "t4_start");
    for (int k = 0; k < 3; k++) step(0, 8'h00, 0, 0, "t4_run");
    for (int k = 0; k < 3; k++) step(0, 8'h00, 1, 1, "t4_hold");
    check("t4_47", 32'(bus.count_out), 32'h47);
    step(0, 8'h00, 1, 0, "t4_resume");
    step(0, 8'h00, 0, 0, "t4_step");
    check("t4_46", 32'(bus.count_out), 32'h46);

    // digit clamp and zero preset
    step(1, 8'h3C, 0, 0, "t5_clamp");
    check("t5_39", 32'(bus.count_out), 32'h39);
    step(1, 8'h00, 0, 0, "t5_zero");
    step(0, 8'h00, 1, 0, "t5_start");
    check("t5_done", 32'(bus.done), 32'd1);

    // load during run wins over start and the decrement
    step(1, 8'h13, 0, 0, "t6_load");
    step(0, 8'h00, 1, 0, "t6_start");
    step(0, 8'h00, 0, 0, "t6_run");
    check("t6_12", 32'(bus.count_out), 32'h12);
    step(1, 8'h34, 1, 0, "t6_reload");
    check("t6_busy", 32'(bus.busy), 32'd0);

    // reset mid-run
    step(1, 8'h40, 0, 0, "t1_load");
    step(0, 8'h00, 1, 0, "t1_start");
    step(0, 8'h00, 0, 0, "t1_run");
    do_reset("t1_reset");

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_reset");
      end else begin
        step(($urandom_range(0, 39) == 0), 8'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 5) == 0), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
